wb_regfile_sequencer: RTL and testbench
=======================================

// Module: wb_regfile_sequencer
// PURPOSE
//  Sequences Y86-64 write-back onto the single-write-port register file.
//  Takes one retired instruction (icode, rA, rB, cnd, valE, valM) over a valid/ready handshake.
//  Decodes up to two destinations: dstE gets valE, dstM gets valM.
//  Issues them as ordered single-port writes (E first, then M), then pulses done to the PC-update stage.
// PARAMETERS
//  DATA_W   64     register data width
//  REG_AW   4      register address width (16 ids, 15 usable)
//  RNONE    4'hF   "no register" id; a destination equal to RNONE is never written
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous, active-high reset
//  in_valid  in   1       write-back request present
//  in_ready  out  1       sequencer can accept a request
//  icode     in   4       instruction code of the retiring instruction
//  rA        in   4       rA field
//  rB        in   4       rB field
//  cnd       in   1       condition result from execute (qualifies cmovxx)
//  valE      in   DATA_W  ALU result
//  valM      in   DATA_W  memory read result
//  rf_we     out  1       register file write enable
//  rf_addr   out  REG_AW  register file write address
//  rf_wdata  out  DATA_W  register file write data
//  busy      out  1       request held (any state other than IDLE)
//  done      out  1       one-cycle pulse: all writes for the request are complete
// BEHAVIOUR
//  Reset (async): state=IDLE; rf_we=0, rf_addr=0, rf_wdata=0, busy=0, done=0; in_ready=0 while rst is high.
//  Accept: in IDLE, in_ready=1; in_valid&&in_ready at an edge captures all inputs. Inputs are ignored outside IDLE.
//  Destination decode from captured fields:
//   dstE = rB for cmovxx(2) when cnd=1, irmovq(3), OPq(6); 4 (%rsp) for call(8), ret(9), pushq(A), popq(B); else RNONE.
//   dstM = rA for mrmovq(5) and popq(B); else RNONE.
//   cmovxx with cnd=0 gives dstE=RNONE. Write-free icodes: halt, nop, rmmovq, jxx, and undefined icodes.
//  FSM: IDLE, WR_E, WR_M, DONE. Moore outputs, driven from registered state and captured data only.
//   IDLE -accept-> WR_E if dstE!=RNONE, else WR_M if dstM!=RNONE, else DONE.
//   WR_E: rf_we=1, rf_addr=dstE, rf_wdata=valE. Next state is WR_M if dstM!=RNONE, else DONE.
//   WR_M: rf_we=1, rf_addr=dstM, rf_wdata=valM. Next state is DONE.
//   DONE: done=1 for exactly one cycle, then IDLE.
//  Latency: accept edge + 1 cycle per write + 1 DONE cycle. Two writes: done 3 cycles after accept.
//   No writes: done 1 cycle after accept.
//  Throughput: next accept no earlier than the cycle after DONE (IDLE re-entered).
//  Collision: dstE==dstM (popq %rsp) performs both writes in order; the M write lands last, so valM wins.
//  rf_we is 0 in IDLE and DONE; rf_addr/rf_wdata hold their last values when rf_we=0.
//  Reset mid-operation: return to IDLE immediately and drop rf_we asynchronously.
//   A completed E write stays committed; the pending M write is lost; no done pulse.
// STRUCTURE
//  Shared package y86_pkg: icode constants (I_HALT..I_POPQ), RNONE, RSP=4, wb state enum.
//  One sub-module wb_dst_decode: combinational icode/rA/rB/cnd -> dstE, dstM.
//   It is reused by the hazard-detect logic.
//  Top level holds the capture registers and the 4-state FSM.
// TESTING
//  1 irmovq rB=3, valE=64'h1234 -> one cycle: rf_we=1, addr=3, data=64'h1234; done 2 cycles after accept.
//  2 popq rA=2, valE=64'h100, valM=64'hBEEF -> writes (4,64'h100) then (2,64'hBEEF) on consecutive cycles; done at +3.
//  3 popq rA=4, valE=64'h100, valM=64'h55 -> both writes go to addr 4; final r4=64'h55.
//  4 cmovxx cnd=0, then halt -> rf_we stays 0 for each; done pulses 1 cycle after each accept.
//  5 Back-to-back: in_valid held high over 3 OPq requests -> in_ready low while busy; requests accepted in order.
//    Exactly 3 writes and 3 done pulses.
//  6 Assert rst during WR_M of a popq -> rf_we drops without waiting for the clock; state=IDLE.
//    r4 keeps the new valE; rA is unchanged; no done pulse.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register ids and
// the write-back sequencer state encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WR_E,
        WB_WR_M,
        WB_DONE
    } wb_state_t;

endpackage

// File: rtl/wb_dst_decode.sv
// Combinational destination decode for write-back; also shared with the
// hazard-detect logic, so it must stay purely a function of its inputs.
module wb_dst_decode
    import y86_pkg::*;
#(
    parameter int                REG_AW    = 4,
    parameter logic [REG_AW-1:0] REG_NONE  = {REG_AW{1'b1}}
) (
    input  logic [3:0]        icode,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic              cnd,
    output logic [REG_AW-1:0] dst_e,
    output logic [REG_AW-1:0] dst_m
);

    // A cmovxx whose condition failed behaves like a nop for write-back.
    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (icode)
            I_CMOVXX: if (cnd) dst_e = rb;
            I_IRMOVQ,
            I_OPQ:    dst_e = rb;
            I_CALL,
            I_RET,
            I_PUSHQ:  dst_e = REG_AW'(RSP);
            I_POPQ: begin
                dst_e = REG_AW'(RSP);
                dst_m = ra;
            end
            I_MRMOVQ: dst_m = ra;
            default: begin
                dst_e = REG_NONE;
                dst_m = REG_NONE;
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile_sequencer.sv
// Serialises the up-to-two write-back results of one retired Y86-64
// instruction onto a single register-file write port, E before M.
module wb_regfile_sequencer
    import y86_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter int                REG_AW = 4,
    parameter logic [REG_AW-1:0] RNONE  = {REG_AW{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [REG_AW-1:0] rA,
    input  logic [REG_AW-1:0] rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done
);

    wb_state_t         state, state_d;
    logic [REG_AW-1:0] dec_e, dec_m;
    logic [REG_AW-1:0] dst_m_q;
    logic [DATA_W-1:0] val_m_q;
    logic              accept;
    logic              we_d;
    logic [REG_AW-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    wb_dst_decode #(
        .REG_AW   (REG_AW),
        .REG_NONE (RNONE)
    ) u_dst_decode (
        .icode (icode),
        .ra    (rA),
        .rb    (rB),
        .cnd   (cnd),
        .dst_e (dec_e),
        .dst_m (dec_m)
    );

    assign in_ready = (state == WB_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != WB_IDLE);
    assign done     = (state == WB_DONE);

    // Write-port outputs are registered alongside the state so they line up
    // with WR_E/WR_M and keep their last value once the write enable drops.
    always_comb begin
        state_d = state;
        we_d    = 1'b0;
        addr_d  = rf_addr;
        wdata_d = rf_wdata;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (dec_e != RNONE) begin
                        state_d = WB_WR_E;
                        we_d    = 1'b1;
                        addr_d  = dec_e;
                        wdata_d = valE;
                    end else if (dec_m != RNONE) begin
                        state_d = WB_WR_M;
                        we_d    = 1'b1;
                        addr_d  = dec_m;
                        wdata_d = valM;
                    end else begin
                        state_d = WB_DONE;
                    end
                end
            end
            WB_WR_E: begin
                if (dst_m_q != RNONE) begin
                    state_d = WB_WR_M;
                    we_d    = 1'b1;
                    addr_d  = dst_m_q;
                    wdata_d = val_m_q;
                end else begin
                    state_d = WB_DONE;
                end
            end
            WB_WR_M: state_d = WB_DONE;
            WB_DONE: state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    // Only the M half needs to outlive the accept edge; E is issued directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WB_IDLE;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            dst_m_q  <= RNONE;
            val_m_q  <= '0;
        end else begin
            state    <= state_d;
            rf_we    <= we_d;
            rf_addr  <= addr_d;
            rf_wdata <= wdata_d;
            if (accept) begin
                dst_m_q <= dec_m;
                val_m_q <= valM;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_sequencer.sv
// Directed self-checking bench for wb_regfile_sequencer with a simple
// register-file model fed by the write port.
module tb_wb_regfile_sequencer;

    localparam int DATA_W = 64;
    localparam int REG_AW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        icode = '0;
    logic [REG_AW-1:0] rA = '0;
    logic [REG_AW-1:0] rB = '0;
    logic              cnd = 1'b0;
    logic [DATA_W-1:0] valE = '0;
    logic [DATA_W-1:0] valM = '0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf_model [16];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_model[rf_addr] <= rf_wdata;
    end

    wb_regfile_sequencer #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .RNONE  (4'hF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .cnd      (cnd),
        .valE     (valE),
        .valM     (valM),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Checks one cycle's write-port/done values, then advances to the next negedge.
    task automatic checkCycle(input string tag, input logic we, input logic [3:0] addr,
                              input logic [63:0] data, input logic dn);
        checkOutput({tag, ".we"},    rf_we,    we);
        checkOutput({tag, ".addr"},  rf_addr,  addr);
        checkOutput({tag, ".wdata"}, rf_wdata, data);
        checkOutput({tag, ".done"},  done,     dn);
        @(negedge clk);
    endtask

    // Presents one request for exactly one accept edge; returns at the next negedge.
    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic c, input logic [63:0] ve, input logic [63:0] vm);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stim.ready", in_ready, 1'b1);
        in_valid = 1'b1;
        icode    = ic;
        rA       = ra;
        rB       = rb;
        cnd      = c;
        valE     = ve;
        valM     = vm;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  k, writes, dones, viol;
        logic acc;

        for (int i = 0; i < 16; i++) rf_model[i] = '0;

        @(negedge clk);
        checkOutput("rst.ready", in_ready, 1'b0);
        checkOutput("rst.we",    rf_we,    1'b0);
        checkOutput("rst.addr",  rf_addr,  4'h0);
        checkOutput("rst.wdata", rf_wdata, 64'h0);
        checkOutput("rst.busy",  busy,     1'b0);
        checkOutput("rst.done",  done,     1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst.ready_after", in_ready, 1'b1);
        @(negedge clk);

        $display("[TB] irmovq single write");
        applyStimulus(4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0);
        checkOutput("t1.busy", busy, 1'b1);
        checkCycle("t1.c1", 1'b1, 4'h3, 64'h1234, 1'b0);
        checkCycle("t1.c2", 1'b0, 4'h3, 64'h1234, 1'b1);
        checkOutput("t1.ready", in_ready, 1'b1);
        checkOutput("t1.r3", rf_model[3], 64'h1234);

        $display("[TB] popq two writes");
        applyStimulus(4'hB, 4'h2, 4'hF, 1'b0, 64'h100, 64'hBEEF);
        checkCycle("t2.c1", 1'b1, 4'h4, 64'h100,  1'b0);
        checkCycle("t2.c2", 1'b1, 4'h2, 64'hBEEF, 1'b0);
        checkCycle("t2.c3", 1'b0, 4'h2, 64'hBEEF, 1'b1);
        checkOutput("t2.r4", rf_model[4], 64'h100);
        checkOutput("t2.r2", rf_model[2], 64'hBEEF);

        $display("[TB] popq %%rsp collision");
        applyStimulus(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h55);
        checkCycle("t3.c1", 1'b1, 4'h4, 64'h100, 1'b0);
        checkCycle("t3.c2", 1'b1, 4'h4, 64'h55,  1'b0);
        checkCycle("t3.c3", 1'b0, 4'h4, 64'h55,  1'b1);
        checkOutput("t3.r4", rf_model[4], 64'h55);

        $display("[TB] write-free instructions");
        applyStimulus(4'h2, 4'h1, 4'h5, 1'b0, 64'hAAAA, 64'h0);
        checkCycle("t4.cmov0", 1'b0, 4'h4, 64'h55, 1'b1);
        checkOutput("t4.r5", rf_model[5], 64'h0);
        applyStimulus(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        checkCycle("t4.halt", 1'b0, 4'h4, 64'h55, 1'b1);
        applyStimulus(4'h4, 4'h1, 4'h2, 1'b0, 64'h9, 64'h9);
        checkCycle("t4.rmmov", 1'b0, 4'h4, 64'h55, 1'b1);
        applyStimulus(4'h2, 4'h1, 4'h6, 1'b1, 64'h77, 64'h0);
        checkCycle("t4.cmov1.c1", 1'b1, 4'h6, 64'h77, 1'b0);
        checkCycle("t4.cmov1.c2", 1'b0, 4'h6, 64'h77, 1'b1);

        $display("[TB] back-to-back OPq");
        k = 0; writes = 0; dones = 0; viol = 0;
        in_valid = 1'b1; icode = 4'h6; rA = 4'hF; rB = 4'h1; cnd = 1'b0;
        valE = 64'h11; valM = 64'h0;
        for (int cyc = 0; cyc < 40 && dones < 3; cyc++) begin
            acc = in_valid && in_ready;
            if (busy && in_ready) viol++;
            if (rf_we) begin
                checkOutput($sformatf("t5.w%0d.addr", writes), rf_addr, 64'(writes + 1));
                checkOutput($sformatf("t5.w%0d.data", writes), rf_wdata, 64'h11 * 64'(writes + 1));
                writes++;
            end
            if (done) dones++;
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 3) begin
                    rB   = 4'(k + 1);
                    valE = 64'h11 * 64'(k + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checkOutput("t5.accepts", 64'(k),      64'd3);
        checkOutput("t5.writes",  64'(writes), 64'd3);
        checkOutput("t5.dones",   64'(dones),  64'd3);
        checkOutput("t5.ready_while_busy", 64'(viol), 64'd0);
        checkOutput("t5.r3", rf_model[3], 64'h33);

        $display("[TB] reset during WR_M");
        applyStimulus(4'hB, 4'h7, 4'hF, 1'b0, 64'h200, 64'h999);
        checkOutput("t6.we_e", rf_we, 1'b1);
        @(negedge clk);
        checkOutput("t6.we_m",   rf_we,   1'b1);
        checkOutput("t6.addr_m", rf_addr, 4'h7);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6.we_async",  rf_we,    1'b0);
        checkOutput("t6.busy",      busy,     1'b0);
        checkOutput("t6.ready_rst", in_ready, 1'b0);
        checkOutput("t6.done_rst",  done,     1'b0);
        @(negedge clk);
        checkOutput("t6.done_hold", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6.done_after", done,     1'b0);
        checkOutput("t6.idle",       busy,     1'b0);
        checkOutput("t6.ready",      in_ready, 1'b1);
        checkOutput("t6.r4",         rf_model[4], 64'h200);
        checkOutput("t6.r7",         rf_model[7], 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
